// File: rtl/organ_pkg.sv
// Shared types, codes and ROM layout for the organ song sequencer.
// Define NOTE_GAP_EN to add a silent gap between consecutive notes.
package organ_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    localparam int SHIFT_W   = 2;
    localparam int NOTE_W    = 3;
    localparam int BEATS_W   = 3;
    localparam int ENTRY_W   = SHIFT_W + NOTE_W + BEATS_W;
    localparam int ROM_DEPTH = 64;
    localparam int ADDR_W    = 6;

    localparam logic [NOTE_W-1:0] REST   = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_C = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_D = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_E = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_F = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_G = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_A = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_B = 3'd7;

    localparam logic [SHIFT_W-1:0] OCT_MID  = 2'd0;
    localparam logic [SHIFT_W-1:0] OCT_LOW  = 2'd1;
    localparam logic [SHIFT_W-1:0] OCT_HIGH = 2'd2;

    localparam logic [BEATS_W-1:0] END_MARKER = 3'd0;

    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic [NOTE_W-1:0]  note;
        logic [BEATS_W-1:0] beats;
    } entry_t;

    typedef logic [ROM_DEPTH-1:0][ENTRY_W-1:0] song_t;

    function automatic logic [ENTRY_W-1:0] mk_entry(
        input logic [SHIFT_W-1:0] s,
        input logic [NOTE_W-1:0]  n,
        input logic [BEATS_W-1:0] b
    );
        return {s, n, b};
    endfunction

    // Lowest pressed key wins; no key pressed gives a rest.
    function automatic logic [NOTE_W-1:0] key_note(input logic [6:0] k);
        logic [NOTE_W-1:0] n;
        n = REST;
        for (int i = 6; i >= 0; i--) begin
            if (k[i]) n = NOTE_W'(i + 1);
        end
        return n;
    endfunction

    function automatic song_t default_song();
        song_t s;
        s = '0;
        s[0] = mk_entry(OCT_MID, NOTE_C, 3'd2);
        s[1] = mk_entry(OCT_MID, NOTE_D, 3'd2);
        s[2] = mk_entry(OCT_MID, NOTE_E, 3'd2);
        s[3] = mk_entry(OCT_MID, NOTE_F, 3'd2);
        s[4] = mk_entry(OCT_MID, NOTE_G, 3'd4);
        s[5] = mk_entry(OCT_MID, REST, 3'd1);
        s[6] = mk_entry(OCT_LOW, NOTE_A, 3'd2);
        s[7] = mk_entry(OCT_LOW, NOTE_B, 3'd2);
        s[8] = mk_entry(OCT_HIGH, NOTE_C, 3'd4);
        s[9] = mk_entry(OCT_MID, REST, END_MARKER);
        return s;
    endfunction

    localparam song_t DEFAULT_SONG = default_song();

endpackage

// File: rtl/song_rom.sv
// 64x8 song ROM with a registered read port (one-cycle latency).
// Contents come from the SONG parameter.
module song_rom
    import organ_pkg::*;
#(
    parameter song_t SONG = DEFAULT_SONG
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] raddr,
    output entry_t            rdata
);

    always_ff @(posedge clk) begin
        rdata <= SONG[raddr];
    end

endmodule

// File: rtl/song_sequencer.sv
// Plays a ROM song into the tone generator, or follows the live keyboard when idle.
// Define NOTE_GAP_EN to insert GAP_CYCLES of silence between notes.
module song_sequencer
    import organ_pkg::*;
#(
    parameter int    BEAT_CYCLES = 25_000_000,
    parameter int    GAP_CYCLES  = 2_500_000,
    parameter song_t SONG        = DEFAULT_SONG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [6:0]        key,
    input  logic [1:0]        key_shift,
    output logic [1:0]        shift,
    output logic [2:0]        note,
    output logic              en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam int PLAY_MAX = 7 * BEAT_CYCLES;
    localparam int CNT_MAX  = (GAP_CYCLES > PLAY_MAX) ? GAP_CYCLES : PLAY_MAX;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [ADDR_W-1:0] addr_t;

    state_t state;
    cnt_t   cnt;
    entry_t ent;
    addr_t  addr_nxt;
    logic   start_ok;
    logic   cnt_zero;
    logic   adv;

    assign start_ok = start && !stop;
    assign cnt_zero = !pause && (cnt == '0);

`ifdef NOTE_GAP_EN
    assign adv = (state == S_GAP) && cnt_zero;
`else
    assign adv = (state == S_PLAY) && cnt_zero && (addr != '1);
`endif

    // The ROM is addressed with the next address so the entry is ready at LOAD exit.
    always_comb begin
        addr_nxt = addr;
        if (rst) begin
            addr_nxt = '0;
        end else if (state == S_IDLE) begin
            if (start_ok) addr_nxt = '0;
        end else if (!stop && adv) begin
            addr_nxt = addr + addr_t'(1);
        end
    end

    song_rom #(.SONG(SONG)) u_rom (
        .clk   (clk),
        .raddr (addr_nxt),
        .rdata (ent)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            addr  <= '0;
            shift <= '0;
            note  <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            addr <= addr_nxt;
            done <= 1'b0;
            if (state != S_IDLE && stop) begin
                state <= S_IDLE;
                shift <= '0;
                note  <= '0;
                en    <= 1'b0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state <= S_LOAD;
                            busy  <= 1'b1;
                            shift <= '0;
                            note  <= '0;
                            en    <= 1'b0;
                        end else begin
                            shift <= key_shift;
                            note  <= key_note(key);
                            en    <= |key;
                        end
                    end
                    S_LOAD: begin
                        if (ent.beats == END_MARKER) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            en    <= 1'b0;
                        end else begin
                            state <= S_PLAY;
                            shift <= ent.shift;
                            note  <= ent.note;
                            en    <= (ent.note != REST);
                            cnt   <= cnt_t'(ent.beats) * cnt_t'(BEAT_CYCLES)
                                     - cnt_t'(1);
                        end
                    end
                    S_PLAY: begin
                        if (pause) begin
                            en <= 1'b0;
                        end else if (cnt != '0) begin
                            cnt <= cnt - cnt_t'(1);
                            en  <= (note != REST);
                        end else begin
                            shift <= '0;
                            note  <= '0;
                            en    <= 1'b0;
                            if (addr == '1) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
`ifdef NOTE_GAP_EN
                                state <= S_GAP;
                                cnt   <= cnt_t'(GAP_CYCLES - 1);
`else
                                state <= S_LOAD;
`endif
                            end
                        end
                    end
`ifdef NOTE_GAP_EN
                    S_GAP: begin
                        if (!pause) begin
                            if (cnt != '0) cnt <= cnt - cnt_t'(1);
                            else state <= S_LOAD;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: key table, hand-written playback sequences,
// and random stimulus against a timeline model built from the song contents.
module tb_song_sequencer;
    import organ_pkg::*;

    localparam int BC = 4;
    localparam int GC = 3;
`ifdef NOTE_GAP_EN
    localparam int GAP_N = GC;
`else
    localparam int GAP_N = 0;
`endif

    function automatic song_t song_a();
        song_t s;
        s = '0;
        s[0] = mk_entry(OCT_MID, NOTE_C, 3'd2);
        s[1] = mk_entry(OCT_HIGH, REST, 3'd1);
        s[2] = mk_entry(OCT_LOW, NOTE_E, 3'd1);
        s[3] = mk_entry(OCT_MID, NOTE_G, 3'd3);
        s[4] = mk_entry(OCT_HIGH, NOTE_B, 3'd1);
        s[5] = mk_entry(OCT_LOW, NOTE_A, 3'd2);
        return s;
    endfunction

    function automatic song_t song_b();
        song_t s;
        for (int i = 0; i < 64; i++) begin
            s[i] = mk_entry(2'(i % 3), 3'((i + 1) % 8), (i % 8 == 5) ? 3'd2 : 3'd1);
        end
        return s;
    endfunction

    function automatic song_t song_c();
        song_t s;
        s = '0;
        s[0] = mk_entry(OCT_MID, NOTE_C, 3'd2);
        return s;
    endfunction

    localparam song_t SONG_A = song_a();
    localparam song_t SONG_B = song_b();
    localparam song_t SONG_C = song_c();

    logic       clk = 1'b0;
    logic       rst, start, stop, pause;
    logic [6:0] key;
    logic [1:0] key_shift;

    logic [1:0] shift_o [3];
    logic [2:0] note_o  [3];
    logic       en_o    [3];
    logic       busy_o  [3];
    logic       done_o  [3];
    logic [5:0] addr_o  [3];

    always #5 clk = ~clk;

    song_sequencer #(.BEAT_CYCLES(BC), .GAP_CYCLES(GC), .SONG(SONG_A)) u_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .key(key), .key_shift(key_shift),
        .shift(shift_o[0]), .note(note_o[0]), .en(en_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .addr(addr_o[0])
    );

    song_sequencer #(.BEAT_CYCLES(BC), .GAP_CYCLES(GC), .SONG(SONG_B)) u_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .key(key), .key_shift(key_shift),
        .shift(shift_o[1]), .note(note_o[1]), .en(en_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .addr(addr_o[1])
    );

    song_sequencer #(.BEAT_CYCLES(BC), .GAP_CYCLES(GC), .SONG(SONG_C)) u_c (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .key(key), .key_shift(key_shift),
        .shift(shift_o[2]), .note(note_o[2]), .en(en_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .addr(addr_o[2])
    );

    // Reference model: on start, the whole playback is unrolled into a queue
    // holding what the outputs show after each unpaused clock edge.
    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_PLAY = 2'd1;
    localparam logic [1:0] K_GAP  = 2'd2;
    localparam logic [1:0] K_END  = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] shift;
        logic [2:0] note;
        logic       en;
        logic [5:0] addr;
    } rec_t;

    rec_t       tl [3][$];
    rec_t       cur [3];
    logic       idle_m [3];
    logic [1:0] e_shift [3];
    logic [2:0] e_note [3];
    logic       e_en [3], e_busy [3], e_done [3];
    logic [5:0] e_addr [3];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, exp);
    endtask

    function automatic logic [7:0] rom_of(input int k, input int a);
        case (k)
            0:       return SONG_A[a];
            1:       return SONG_B[a];
            default: return SONG_C[a];
        endcase
    endfunction

    function automatic logic [2:0] lowest(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    task automatic build(input int k);
        logic [7:0] e;
        tl[k].delete();
        for (int a = 0; a < 64; a++) begin
            e = rom_of(k, a);
            tl[k].push_back('{K_LOAD, 2'd0, 3'd0, 1'b0, 6'(a)});
            if (e[2:0] == 3'd0) begin
                tl[k].push_back('{K_END, 2'd0, 3'd0, 1'b0, 6'(a)});
                return;
            end
            for (int c = 0; c < e[2:0] * BC; c++)
                tl[k].push_back('{K_PLAY, e[7:6], e[5:3], (e[5:3] != 3'd0), 6'(a)});
            if (a == 63) begin
                tl[k].push_back('{K_END, 2'd0, 3'd0, 1'b0, 6'd63});
                return;
            end
            for (int c = 0; c < GAP_N; c++)
                tl[k].push_back('{K_GAP, 2'd0, 3'd0, 1'b0, 6'(a)});
        end
    endtask

    task automatic go_idle(input int k);
        idle_m[k]  = 1'b1;
        e_shift[k] = '0;
        e_note[k]  = '0;
        e_en[k]    = 1'b0;
        e_busy[k]  = 1'b0;
        tl[k].delete();
    endtask

    task automatic show(input int k);
        e_shift[k] = cur[k].shift;
        e_note[k]  = cur[k].note;
        e_en[k]    = cur[k].en;
        e_addr[k]  = cur[k].addr;
        e_busy[k]  = 1'b1;
    endtask

    task automatic model_edge(input int k);
        e_done[k] = 1'b0;
        if (rst) begin
            go_idle(k);
            e_addr[k] = '0;
        end else if (idle_m[k]) begin
            if (start && !stop) begin
                build(k);
                cur[k] = tl[k].pop_front();
                idle_m[k] = 1'b0;
                show(k);
            end else begin
                e_shift[k] = key_shift;
                e_note[k]  = lowest(key);
                e_en[k]    = |key;
            end
        end else if (stop) begin
            go_idle(k);
        end else if (pause && (cur[k].kind == K_PLAY || cur[k].kind == K_GAP)) begin
            e_en[k] = 1'b0;
        end else if (tl[k].size() == 0) begin
            go_idle(k);
        end else begin
            cur[k] = tl[k].pop_front();
            if (cur[k].kind == K_END) begin
                go_idle(k);
                e_addr[k] = cur[k].addr;
                e_done[k] = 1'b1;
            end else begin
                show(k);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("model_u%0d", k),
                {shift_o[k], note_o[k], en_o[k], busy_o[k], done_o[k], addr_o[k]},
                {e_shift[k], e_note[k], e_en[k], e_busy[k], e_done[k], e_addr[k]});
    endtask

    typedef struct {
        logic [6:0] key;
        logic [1:0] ks;
        logic       st;
        logic       sp;
        logic [2:0] note;
        logic [1:0] shift;
        logic       en;
        logic       busy;
    } kv_t;

    kv_t kv [8];

    initial begin
        int guard, lo, first, en_n, done_n, done_at, bad;

        for (int k = 0; k < 3; k++) begin
            idle_m[k] = 1'b1;
            e_shift[k] = '0; e_note[k] = '0; e_en[k] = 1'b0;
            e_busy[k] = 1'b0; e_done[k] = 1'b0; e_addr[k] = '0;
        end
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        key = '0; key_shift = '0;

        step();
        step();
        chk("reset_state", {shift_o[0], note_o[0], en_o[0], busy_o[0], done_o[0], addr_o[0]}, 0);
        rst = 1'b0;

        kv[0] = '{7'b0010100, 2'd2, 1'b0, 1'b0, 3'd3, 2'd2, 1'b1, 1'b0};
        kv[1] = '{7'b0000000, 2'd1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0};
        kv[2] = '{7'b1000000, 2'd1, 1'b0, 1'b0, 3'd7, 2'd1, 1'b1, 1'b0};
        kv[3] = '{7'b1111111, 2'd3, 1'b0, 1'b0, 3'd1, 2'd3, 1'b1, 1'b0};
        kv[4] = '{7'b0100001, 2'd0, 1'b0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0};
        kv[5] = '{7'b0001000, 2'd2, 1'b1, 1'b1, 3'd4, 2'd2, 1'b1, 1'b0};
        kv[6] = '{7'b0000010, 2'd0, 1'b0, 1'b1, 3'd2, 2'd0, 1'b1, 1'b0};
        kv[7] = '{7'b0110000, 2'd1, 1'b0, 1'b0, 3'd5, 2'd1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            key = kv[i].key; key_shift = kv[i].ks;
            start = kv[i].st; stop = kv[i].sp;
            step();
            chk($sformatf("key_vec%0d", i),
                {note_o[0], shift_o[0], en_o[0], busy_o[0]},
                {kv[i].note, kv[i].shift, kv[i].en, kv[i].busy});
        end
        start = 1'b0; stop = 1'b0; key = '0; key_shift = '0;

        // Single two-beat note followed by the end marker
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("c_load_state", {busy_o[2], en_o[2]}, 2'b10);
        first = -1; en_n = 0; done_n = 0; done_at = -1;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (en_o[2]) begin
                if (first < 0) first = j;
                en_n++;
            end
            if (done_o[2]) begin
                done_n++;
                done_at = j;
            end
        end
        chk("c_first_en_edge", first, 1);
        chk("c_en_cycles", en_n, 2 * BC);
        chk("c_done_pulses", done_n, 1);
        chk("c_done_edge", done_at, 10 + GAP_N);
        chk("c_busy_after", busy_o[2], 0);

        // Pause for five cycles in the middle of the first note
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        en_n = 0; bad = 0;
        for (int j = 0; j < 2; j++) begin
            step();
            if (en_o[0] && addr_o[0] == 6'd0) en_n++;
        end
        pause = 1'b1;
        for (int j = 0; j < 5; j++) begin
            step();
            if (en_o[0] || addr_o[0] != 6'd0) bad++;
        end
        pause = 1'b0;
        guard = 0;
        while (addr_o[0] == 6'd0 && guard < 40) begin
            step();
            guard++;
            if (en_o[0] && addr_o[0] == 6'd0) en_n++;
        end
        chk("pause_en_low", bad, 0);
        chk("pause_en_total", en_n, 2 * BC);
        chk("pause_wait_ok", guard < 40, 1);

        // Silence between the notes at addresses 2 and 3
        guard = 0;
        while (!(en_o[0] && addr_o[0] == 6'd2) && guard < 100) begin
            step();
            guard++;
        end
        chk("reach_addr2", guard < 100, 1);
        guard = 0;
        while (en_o[0] && guard < 20) begin
            step();
            guard++;
        end
        lo = 0;
        while (!en_o[0] && guard < 40) begin
            lo++;
            step();
            guard++;
        end
        chk("gap_low_cycles", lo, GAP_N + 1);
        chk("gap_next_addr", addr_o[0], 3);

        // Stop at address 3, then restart
        stop = 1'b1; step(); stop = 1'b0;
        chk("stop_outputs", {en_o[0], busy_o[0], done_o[0]}, 0);
        done_n = 0;
        for (int j = 0; j < 5; j++) begin
            step();
            if (done_o[0]) done_n++;
        end
        chk("stop_no_done", done_n, 0);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_addr", {busy_o[0], addr_o[0]}, {1'b1, 6'd0});
        step();
        chk("restart_note", {en_o[0], note_o[0]}, {1'b1, 3'd1});

        // Song without an end marker runs through address 63
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        guard = 0;
        while (!done_o[1] && guard < 1500) begin
            step();
            guard++;
        end
        chk("b_done_seen", guard < 1500, 1);
        chk("b_done_addr", {addr_o[1], busy_o[1], en_o[1]}, {6'd63, 1'b0, 1'b0});
        done_n = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (done_o[1]) done_n++;
        end
        chk("b_single_done", done_n, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int j = 0; j < 3; j++) step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("b_rst_mid_note", {shift_o[1], note_o[1], en_o[1], busy_o[1], done_o[1], addr_o[1]}, 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            start = ($urandom_range(0, 24) == 0);
            stop = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            if ($urandom_range(0, 7) == 0) key = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom);
            key_shift = 2'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
